// File: rtl/pq_selftest.sv
// pq_selftest: self-test sequencer for a priority queue.
//
// The block runs fill/drain rounds against the queue client port. Keys come from a 32-bit
// Galois LFSR and the value field carries the enqueue index. Each drained stream is checked
// for ordering, element count and an XOR checksum of the keys. Errors accumulate across
// rounds. The first failure is captured, and the result is shown on flags and RGB LEDs.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               level input; a registered rising edge begins a run
//   abort               synchronous return to IDLE (counters hold)
//   pq_full/empty/busy  queue status
//   pq_kvo              queue head {key, value}
//   pq_replace, pq_deq  one-cycle operation strobes (combinational)
//   pq_kvi              {key, value} for enqueue (combinational)
//   done/pass/fail      run result; stall flags a busy watchdog expiry
//   state_o             IDLE=0 PURGE=1 SEED=2 FILL=3 DRAIN=4 CHECK=5 DONE=6
//   err_count           saturating error counter
//   round_count         saturating round counter
//   first_bad_kvo/idx   head value and index seen at the first error of the run
//   led_r/g/b           blue while running, green on pass, red on fail
module pq_selftest #(
  parameter int unsigned KW        = 8,
  parameter int unsigned VW        = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ROUNDS    = 1,
  parameter int unsigned MAX_FIRST = 1,
  parameter logic [31:0] SEED      = 32'hACE1_1234,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pq_full,
  input  logic             pq_empty,
  input  logic             pq_busy,
  input  logic [KW+VW-1:0] pq_kvo,
  output logic             pq_replace,
  output logic             pq_deq,
  output logic [KW+VW-1:0] pq_kvi,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             stall,
  output logic [2:0]       state_o,
  output logic [15:0]      err_count,
  output logic [15:0]      round_count,
  output logic [KW+VW-1:0] first_bad_kvo,
  output logic [15:0]      first_bad_idx,
  output logic [2:0]       led_r,
  output logic [2:0]       led_g,
  output logic [2:0]       led_b
);

  localparam int unsigned DW        = KW + VW;
  localparam int unsigned WdW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] TimeoutM1 = WdW'(TIMEOUT - 1);
  localparam logic [15:0] DepthW    = 16'(DEPTH);
  // Galois feedback mask for taps 32, 22, 2, 1.
  localparam logic [31:0] LfsrTaps  = 32'h8020_0003;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPurge = 3'd1,
    StSeed  = 3'd2,
    StFill  = 3'd3,
    StDrain = 3'd4,
    StCheck = 3'd5,
    StDone  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic            start_q, start_prev_q;
  logic [31:0]     lfsr_q, lfsr_d, lfsr_adv;
  logic [15:0]     enq_cnt_q, enq_cnt_d, deq_cnt_q, deq_cnt_d;
  logic [KW-1:0]   xor_in_q, xor_in_d, xor_out_q, xor_out_d, prev_q, prev_d;
  logic            have_prev_q, have_prev_d;
  logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
  logic [15:0]     err_count_q, err_count_d, round_count_q, round_count_d;
  logic [DW-1:0]   first_bad_kvo_q, first_bad_kvo_d;
  logic [15:0]     first_bad_idx_q, first_bad_idx_d;
  logic            stall_q, stall_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [2:0]      led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;

  logic            start_rise, run_state, run_next, timeout, order_bad;
  logic [1:0]      err_inc;
  logic [16:0]     err_sum;
  logic [KW-1:0]   head_key;

  assign start_rise = start_q & ~start_prev_q;
  assign run_state  = (state_q == StPurge) || (state_q == StFill) || (state_q == StDrain);
  assign head_key   = pq_kvo[DW-1:VW];
  assign lfsr_adv   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  assign order_bad  = (MAX_FIRST != 0) ? (head_key > prev_q) : (head_key < prev_q);

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      start_q         <= 1'b0;
      start_prev_q    <= 1'b0;
      lfsr_q          <= SEED;
      enq_cnt_q       <= '0;
      deq_cnt_q       <= '0;
      xor_in_q        <= '0;
      xor_out_q       <= '0;
      prev_q          <= '0;
      have_prev_q     <= 1'b0;
      wd_cnt_q        <= '0;
      err_count_q     <= '0;
      round_count_q   <= '0;
      first_bad_kvo_q <= '0;
      first_bad_idx_q <= '0;
      stall_q         <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      led_r_q         <= '0;
      led_g_q         <= '0;
      led_b_q         <= '0;
    end else begin
      state_q         <= state_d;
      start_q         <= start;
      start_prev_q    <= start_q;
      lfsr_q          <= lfsr_d;
      enq_cnt_q       <= enq_cnt_d;
      deq_cnt_q       <= deq_cnt_d;
      xor_in_q        <= xor_in_d;
      xor_out_q       <= xor_out_d;
      prev_q          <= prev_d;
      have_prev_q     <= have_prev_d;
      wd_cnt_q        <= wd_cnt_d;
      err_count_q     <= err_count_d;
      round_count_q   <= round_count_d;
      first_bad_kvo_q <= first_bad_kvo_d;
      first_bad_idx_q <= first_bad_idx_d;
      stall_q         <= stall_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      led_r_q         <= led_r_d;
      led_g_q         <= led_g_d;
      led_b_q         <= led_b_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    enq_cnt_d       = enq_cnt_q;
    deq_cnt_d       = deq_cnt_q;
    xor_in_d        = xor_in_q;
    xor_out_d       = xor_out_q;
    prev_d          = prev_q;
    have_prev_d     = have_prev_q;
    wd_cnt_d        = '0;
    err_count_d     = err_count_q;
    round_count_d   = round_count_q;
    first_bad_kvo_d = first_bad_kvo_q;
    first_bad_idx_d = first_bad_idx_q;
    stall_d         = stall_q;
    timeout         = 1'b0;
    err_inc         = 2'd0;
    err_sum         = {1'b0, err_count_q};

    if (abort) begin
      // Only the state moves; counters and queue contents are left alone.
      state_d = StIdle;
    end else begin
      if (run_state && pq_busy) begin
        if (wd_cnt_q == TimeoutM1) begin
          timeout = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      if (timeout) begin
        state_d = StDone;
        stall_d = 1'b1;
        err_inc = 2'd1;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (start_rise) begin
              err_count_d     = '0;
              round_count_d   = '0;
              first_bad_kvo_d = '0;
              first_bad_idx_d = '0;
              stall_d         = 1'b0;
              state_d         = StPurge;
            end
          end
          StPurge: begin
            if (pq_empty) state_d = StSeed;
          end
          StSeed: begin
            lfsr_d      = SEED ^ {16'b0, round_count_q};
            enq_cnt_d   = '0;
            deq_cnt_d   = '0;
            xor_in_d    = '0;
            xor_out_d   = '0;
            have_prev_d = 1'b0;
            state_d     = StFill;
          end
          StFill: begin
            if (pq_replace) begin
              lfsr_d    = lfsr_adv;
              enq_cnt_d = enq_cnt_q + 16'd1;
              xor_in_d  = xor_in_q ^ lfsr_q[KW-1:0];
            end
            if (pq_full || (enq_cnt_q == DepthW)) begin
              state_d = StDrain;
              // Queue reported full early, or not full once DEPTH entries went in.
              if ((pq_full && (enq_cnt_q < DepthW)) || (!pq_full && (enq_cnt_q == DepthW))) begin
                err_inc = 2'd1;
              end
            end
          end
          StDrain: begin
            if (pq_deq) begin
              if (have_prev_q && order_bad) err_inc = 2'd1;
              prev_d      = head_key;
              have_prev_d = 1'b1;
              deq_cnt_d   = deq_cnt_q + 16'd1;
              xor_out_d   = xor_out_q ^ head_key;
            end
            if (pq_empty) state_d = StCheck;
          end
          StCheck: begin
            err_inc = {1'b0, deq_cnt_q != enq_cnt_q} + {1'b0, xor_in_q != xor_out_q};
            if (round_count_q != 16'hFFFF) round_count_d = round_count_q + 16'd1;
            if ((ROUNDS == 0) || (({16'b0, round_count_q} + 32'd1) < ROUNDS)) begin
              state_d = StSeed;
            end else begin
              state_d = StDone;
            end
          end
          default: state_d = StIdle;
        endcase
      end

      err_sum = {1'b0, err_count_q} + {15'b0, err_inc};
      if (err_inc != 2'd0) begin
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        // err_count never wraps, so zero means no error yet in this run.
        if (err_count_q == 16'd0) begin
          first_bad_kvo_d = pq_kvo;
          first_bad_idx_d = (state_q == StFill) ? enq_cnt_q : deq_cnt_q;
        end
      end
    end
  end

  // Registered status outputs follow the next state so they line up with state_o.
  always_comb begin
    run_next = (state_d != StIdle) && (state_d != StDone);
    done_d   = (state_d == StDone);
    pass_d   = done_d && (err_count_d == 16'd0);
    fail_d   = done_d && (err_count_d != 16'd0);
    led_g_d  = {3{pass_d}};
    led_r_d  = {3{fail_d}};
    led_b_d  = {3{run_next}};
  end

  // Queue strobes: combinational from registered state and queue status.
  always_comb begin
    pq_replace = 1'b0;
    pq_deq     = 1'b0;
    pq_kvi     = '0;
    case (state_q)
      StPurge: pq_deq = !pq_busy && !pq_empty;
      StFill: begin
        pq_replace = !pq_busy && !pq_full && (enq_cnt_q < DepthW);
        pq_kvi     = {lfsr_q[KW-1:0], enq_cnt_q[VW-1:0]};
      end
      StDrain: pq_deq = !pq_busy && !pq_empty;
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign stall         = stall_q;
  assign err_count     = err_count_q;
  assign round_count   = round_count_q;
  assign first_bad_kvo = first_bad_kvo_q;
  assign first_bad_idx = first_bad_idx_q;
  assign led_r         = led_r_q;
  assign led_g         = led_g_q;
  assign led_b         = led_b_q;

endmodule

// File: tb/tb_pq_selftest.sv
// Bench for pq_selftest: DEPTH=4, ROUNDS=2, 8-bit keys and values, max-first queue.
// A behavioural sorted-array queue sits on the client port. It can inject a swapped
// drain order or an early full flag.
module tb_pq_selftest;

  localparam int MD = 8;

  logic        clk, rst, start, abort;
  logic        pq_full, pq_empty, pq_busy;
  logic [15:0] pq_kvo, pq_kvi;
  logic        pq_replace, pq_deq;
  logic        done, pass, fail, stall;
  logic [2:0]  state_o;
  logic [15:0] err_count, round_count, first_bad_kvo, first_bad_idx;
  logic [2:0]  led_r, led_g, led_b;

  pq_selftest #(
    .KW(8), .VW(8), .DEPTH(4), .ROUNDS(2), .MAX_FIRST(1),
    .SEED(32'hACE1_1234), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy), .pq_kvo(pq_kvo),
    .pq_replace(pq_replace), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
    .done(done), .pass(pass), .fail(fail), .stall(stall), .state_o(state_o),
    .err_count(err_count), .round_count(round_count),
    .first_bad_kvo(first_bad_kvo), .first_bad_idx(first_bad_idx),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: entries kept sorted by key, largest first.
  logic        m_rst_n, m_busy, m_swap;
  int          m_cap;
  logic [15:0] m_arr [MD];
  logic [15:0] m_arr_d [MD];
  int          m_cnt, m_cnt_d, m_pos, m_pos_d, m_sel, m_p;

  assign m_sel    = (m_swap && m_pos == 1 && m_cnt >= 2) ? 1 : 0;
  assign pq_kvo   = m_arr[m_sel];
  assign pq_empty = (m_cnt == 0);
  assign pq_full  = (m_cnt >= m_cap);
  assign pq_busy  = m_busy;

  always_comb begin
    for (int i = 0; i < MD; i++) m_arr_d[i] = m_arr[i];
    m_cnt_d = m_cnt;
    m_pos_d = m_pos;
    m_p     = 0;
    if (pq_deq && m_cnt > 0) begin
      for (int i = 0; i < MD - 1; i++) if (i >= m_sel) m_arr_d[i] = m_arr[i + 1];
      m_cnt_d = m_cnt - 1;
      m_pos_d = m_pos + 1;
    end else if (pq_replace && m_cnt < MD) begin
      for (int i = 0; i < MD; i++) if (i < m_cnt && m_arr[i][15:8] >= pq_kvi[15:8]) m_p++;
      for (int i = 1; i < MD; i++) if (i > m_p) m_arr_d[i] = m_arr[i - 1];
      m_arr_d[m_p] = pq_kvi;
      m_cnt_d = m_cnt + 1;
      m_pos_d = 0;
    end
  end

  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      m_cnt <= 0;
      m_pos <= 0;
      for (int i = 0; i < MD; i++) m_arr[i] <= '0;
    end else begin
      m_cnt <= m_cnt_d;
      m_pos <= m_pos_d;
      for (int i = 0; i < MD; i++) m_arr[i] <= m_arr_d[i];
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int          n_rep, n_ddeq, n_pdeq, n_both;
  logic [15:0] kvi_log [64];
  initial begin
    n_rep = 0; n_ddeq = 0; n_pdeq = 0; n_both = 0;
  end
  always begin
    @(posedge clk);
    #4;
    if (pq_replace) begin
      if (n_rep < 64) kvi_log[n_rep] = pq_kvi;
      n_rep++;
    end
    if (pq_deq && state_o == 3'd4) n_ddeq++;
    if (pq_deq && state_o == 3'd1) n_pdeq++;
    if (pq_replace && pq_deq) n_both++;
  end

  int total, bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Start edge: state is unchanged after one edge and PURGE after two.
  task automatic kick(input string name, input logic [2:0] from_state);
    start = 1'b1;
    cyc();
    check({name, "_lat1"}, state_o, from_state);
    cyc();
    check({name, "_lat2"}, state_o, 3'd1);
    start = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [2:0] tgt, input int budget);
    int n;
    n = 0;
    while (state_o !== tgt && n < budget) begin
      cyc();
      n++;
    end
    check(name, state_o, tgt);
  endtask

  typedef struct {
    string       name;
    int          cap0;
    bit          swap;
    int          exp_rep;
    int          exp_deq;
    logic [15:0] exp_err;
    logic [15:0] exp_idx;
    logic [15:0] exp_kvo;
    bit          exp_pass;
  } scen_t;

  scen_t       sc [3];
  logic [15:0] exp_kvi [8];
  int          rb, db, pb, k;

  initial begin
    total = 0; bad = 0;
    // Round 0 keys from SEED, round 1 from SEED^1; value = enqueue index.
    exp_kvi[0] = 16'h3400; exp_kvi[1] = 16'h1A01; exp_kvi[2] = 16'h8D02; exp_kvi[3] = 16'h4503;
    exp_kvi[4] = 16'h3500; exp_kvi[5] = 16'h1901; exp_kvi[6] = 16'h8F02; exp_kvi[7] = 16'h4403;
    //        name     cap swap rep deq err idx     kvo      pass
    sc[0] = '{"ideal", 4,  0,   8,  8,  0,  16'd0,  16'h0000, 1};
    sc[1] = '{"swap",  4,  1,   8,  8,  1,  16'd2,  16'h4503, 0};
    sc[2] = '{"cap",   3,  0,   7,  7,  1,  16'd3,  16'h8D02, 0};

    rst = 1'b0; m_rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    m_busy = 1'b0; m_swap = 1'b0; m_cap = 4;
    cyc(); cyc();
    check("rst_state", state_o, 3'd0);
    check("rst_err", err_count, 16'd0);
    check("rst_round", round_count, 16'd0);
    check("rst_flags", {done, pass, fail, stall}, 4'b0000);
    check("rst_leds", {led_r, led_g, led_b}, 9'd0);
    check("rst_kvi", pq_kvi, 16'd0);
    rst = 1'b1; m_rst_n = 1'b1;
    cyc();

    for (int s = 0; s < 3; s++) begin
      m_cap  = sc[s].cap0;
      m_swap = sc[s].swap;
      rb = n_rep; db = n_ddeq;
      kick(sc[s].name, (s == 0) ? 3'd0 : 3'd6);
      k = 0;
      while (round_count !== 16'd1 && k < 200) begin
        cyc();
        k++;
      end
      check($sformatf("%s_round1", sc[s].name), round_count, 16'd1);
      m_cap = 4; m_swap = 1'b0;
      wait_state($sformatf("%s_done", sc[s].name), 3'd6, 200);
      check($sformatf("%s_rep", sc[s].name), n_rep - rb, sc[s].exp_rep);
      check($sformatf("%s_deq", sc[s].name), n_ddeq - db, sc[s].exp_deq);
      check($sformatf("%s_err", sc[s].name), err_count, sc[s].exp_err);
      check($sformatf("%s_rounds", sc[s].name), round_count, 16'd2);
      check($sformatf("%s_flags", sc[s].name), {done, pass, fail},
            {1'b1, sc[s].exp_pass, !sc[s].exp_pass});
      check($sformatf("%s_leds", sc[s].name), {led_r, led_g, led_b},
            sc[s].exp_pass ? 9'b000_111_000 : 9'b111_000_000);
      check($sformatf("%s_idx", sc[s].name), first_bad_idx, sc[s].exp_idx);
      check($sformatf("%s_kvo", sc[s].name), first_bad_kvo, sc[s].exp_kvo);
      if (s == 0) begin
        for (int i = 0; i < 8; i++) begin
          check($sformatf("ideal_kvi%0d", i), kvi_log[rb + i], exp_kvi[i]);
        end
      end
    end

    // Watchdog: busy stuck high in FILL after two enqueues.
    rb = n_rep;
    kick("wd", 3'd6);
    k = 0;
    while (!(state_o == 3'd3 && n_rep - rb >= 2) && k < 100) begin
      cyc();
      k++;
    end
    check("wd_fill2", n_rep - rb, 2);
    m_busy = 1'b1;
    k = 0;
    while (state_o !== 3'd6 && k < 1100) begin
      cyc();
      k++;
    end
    check("wd_latency", k, 1024);
    repeat (76) cyc();
    m_busy = 1'b0;
    check("wd_rep_held", n_rep - rb, 2);
    check("wd_stall", stall, 1'b1);
    check("wd_err", err_count, 16'd1);
    check("wd_flags", {done, pass, fail}, 3'b101);
    check("wd_led_r", led_r, 3'b111);
    check("wd_idx", first_bad_idx, 16'd2);
    check("wd_kvo", first_bad_kvo, 16'h3400);

    // Abort in DRAIN with two entries left, then a clean rerun.
    kick("ab", 3'd6);
    k = 0;
    while (!(state_o == 3'd4 && m_cnt == 3) && k < 100) begin
      cyc();
      k++;
    end
    check("ab_in_drain", state_o, 3'd4);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("ab_idle", state_o, 3'd0);
    check("ab_left", m_cnt, 2);
    check("ab_round_hold", round_count, 16'd0);
    check("ab_leds", {led_r, led_g, led_b}, 9'd0);
    pb = n_pdeq;
    kick("ab_re", 3'd0);
    wait_state("ab_done", 3'd6, 200);
    check("ab_purge_deq", n_pdeq - pb, 2);
    check("ab_err", err_count, 16'd0);
    check("ab_pass", {done, pass, fail}, 3'b110);
    check("ab_rounds", round_count, 16'd2);

    // Asynchronous reset in the middle of round 1 FILL.
    kick("rs", 3'd6);
    k = 0;
    while (!(state_o == 3'd3 && round_count == 16'd1) && k < 200) begin
      cyc();
      k++;
    end
    check("rs_fill", state_o, 3'd3);
    check("rs_rep_pre", pq_replace, 1'b1);
    check("rs_led_b_pre", led_b, 3'b111);
    rst = 1'b0;
    #1;
    check("rs_rep_async", pq_replace, 1'b0);
    check("rs_state_async", state_o, 3'd0);
    check("rs_round_async", round_count, 16'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();
    check("rs_state", state_o, 3'd0);
    check("rs_counts", {err_count, round_count, first_bad_idx}, 48'd0);
    check("rs_kvo", first_bad_kvo, 16'd0);
    check("rs_flags", {done, pass, fail, stall}, 4'b0000);
    check("rs_leds", {led_r, led_g, led_b}, 9'd0);

    check("never_both", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
